spike_event_encoder: RTL and testbench

- Downstream consumer of the LIF neuron's spike_out vector.
- Converts each asserted spike bit into an address-event (neuron id plus timestamp).
- Serializes the events one per cycle into a small show-ahead FIFO.
- Presents the events on a valid/ready port to the chip pin logic or a readout stage, and tracks dropped events.

---
 rtl/snn_pkg.sv | 30 +++
 rtl/spike_event_encoder_if.sv | 13 +
 rtl/snn_event_fifo.sv | 43 ++++
 rtl/spike_event_encoder.sv | 86 ++++++++
 tb/tb_spike_event_encoder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network event path.
package snn_pkg;
  localparam int ID_WIDTH_DEF = 2;
  localparam int TS_WIDTH_DEF = 8;
  localparam int PE_MAX       = 32;
  localparam int PE_IDX_W     = 5;

  typedef struct packed {
    logic [ID_WIDTH_DEF-1:0] id;
    logic [TS_WIDTH_DEF-1:0] ts;
  } evt_t;

  typedef struct packed {
    logic                found;
    logic [PE_IDX_W-1:0] idx;
  } pe_t;

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  function automatic pe_t lowest_set(input logic [PE_MAX-1:0] vec);
    pe_t r;
    r = '0;
    for (int i = PE_MAX-1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = i[PE_IDX_W-1:0];
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/spike_event_encoder_if.sv
// Address-event output port: show-ahead valid/ready with id and timestamp.
interface spike_event_encoder_if import snn_pkg::*; #(
  parameter int ID_WIDTH = ID_WIDTH_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF
);
  logic                evt_valid;
  logic                evt_ready;
  logic [ID_WIDTH-1:0] evt_id;
  logic [TS_WIDTH-1:0] evt_ts;

  modport master (output evt_valid, evt_id, evt_ts, input evt_ready);
  modport slave  (input evt_valid, evt_id, evt_ts, output evt_ready);
endinterface

// File: rtl/snn_event_fifo.sv
// Synchronous show-ahead FIFO; full/empty come from the level counter.
module snn_event_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/spike_event_encoder.sv
// Turns spike vectors into timestamped address-events, one per cycle, into
// a show-ahead FIFO; spikes arriving while a vector is still pending are dropped.
module spike_event_encoder import snn_pkg::*; #(
  parameter int NUM_NEURONS = 3,
  parameter int ID_WIDTH    = ID_WIDTH_DEF,
  parameter int TS_WIDTH    = TS_WIDTH_DEF,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   clear_stats,
  spike_event_encoder_if.master  evt,
  output logic [LVL_W-1:0]       fifo_level,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   drop_count
);
  localparam int DATA_W = ID_WIDTH + TS_WIDTH;

  logic [TS_WIDTH-1:0]    ts_cnt, pend_ts;
  logic [NUM_NEURONS-1:0] mask, mask_next, push_bit;
  logic [DATA_W-1:0]      wr_data, rd_data;
  logic [CNT_WIDTH:0]     drop_sum;
  logic                   full, empty, pop, push, sample, drop;
  pe_t                    pe;

  assign pe        = lowest_set(PE_MAX'(mask));
  assign pop       = !empty && evt.evt_ready;
  assign push      = pe.found && (!full || pop);
  assign push_bit  = push ? (NUM_NEURONS'(1) << pe.idx) : '0;
  assign mask_next = mask & ~push_bit;
  assign sample    = enable && (spike_in != '0);
  // A new vector is only accepted if the pending one drains on this very edge.
  assign drop      = sample && (mask_next != '0);
  assign wr_data   = {pe.idx[ID_WIDTH-1:0], pend_ts};

  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < NUM_NEURONS; i++)
      drop_sum = drop_sum + (CNT_WIDTH+1)'(spike_in[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt     <= '0;
      mask       <= '0;
      pend_ts    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (enable) ts_cnt <= ts_cnt + 1'b1;
      if (sample && !drop) begin
        mask    <= spike_in;
        pend_ts <= ts_cnt;
      end else begin
        mask <= mask_next;
      end
      if (clear_stats) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overflow   <= 1'b1;
        drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      end
    end
  end

  snn_event_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign evt.evt_valid = !empty;
  assign evt.evt_id    = rd_data[DATA_W-1 -: ID_WIDTH];
  assign evt.evt_ts    = rd_data[TS_WIDTH-1:0];
endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed + random bench for spike_event_encoder against a queue-based event model.
module tb_spike_event_encoder;
  import snn_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] spike_in = '0;
  logic       clear_stats = 1'b0;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_count;

  spike_event_encoder_if #(.ID_WIDTH(2), .TS_WIDTH(8)) evt ();

  spike_event_encoder #(
    .NUM_NEURONS(3), .ID_WIDTH(2), .TS_WIDTH(8), .FIFO_DEPTH(8), .CNT_WIDTH(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spike_in    (spike_in),
    .clear_stats (clear_stats),
    .evt         (evt),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: pending spikes as a list of ids, FIFO as a queue of events.
  int   m_ts;
  int   m_pts;
  int   m_pend[$];
  evt_t m_fifo[$];
  int   m_drop;
  bit   m_ovf;

  task automatic model_reset();
    m_ts = 0; m_pts = 0; m_pend.delete(); m_fifo.delete(); m_drop = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit   pop, push_ok, do_push;
    evt_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop     = (m_fifo.size() != 0) && evt.evt_ready;
    push_ok = (m_fifo.size() < 8) || pop;
    do_push = 0;
    e       = '0;
    if (m_pend.size() != 0 && push_ok) begin
      e.id    = 2'(m_pend.pop_front());
      e.ts    = 8'(m_pts);
      do_push = 1;
    end
    if (enable && spike_in != 0) begin
      if (m_pend.size() == 0) begin
        for (int i = 0; i < 3; i++) if (spike_in[i]) m_pend.push_back(i);
        m_pts = m_ts;
      end else begin
        m_drop = m_drop + $countones(spike_in);
        if (m_drop > 255) m_drop = 255;
        m_ovf = 1;
      end
    end
    if (clear_stats) begin
      m_drop = 0; m_ovf = 0;
    end
    if (enable) m_ts = (m_ts + 1) % 256;
    if (pop) void'(m_fifo.pop_front());
    if (do_push) m_fifo.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("evt_valid", 32'(evt.evt_valid), 32'(m_fifo.size() != 0));
    chk("evt_id", 32'(evt.evt_id), m_fifo.size() != 0 ? 32'(m_fifo[0].id) : 32'd0);
    chk("evt_ts", 32'(evt.evt_ts), m_fifo.size() != 0 ? 32'(m_fifo[0].ts) : 32'd0);
    chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("ts_cnt", 32'(dut.ts_cnt), 32'(m_ts));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_ts(input int t);
    spike_in = '0;
    enable   = 1'b1;
    for (int k = 0; k < 300 && m_ts != t; k++) cycle();
    chk("reach_ts", 32'(dut.ts_cnt), 32'(t));
  endtask

  initial begin
    model_reset();
    // Reset state, asserted asynchronously
    #2 rst_n = 1'b0;
    #1 check_all();
    repeat (3) cycle();
    rst_n = 1'b1;

    // Idle for 10 enabled cycles
    enable = 1'b1;
    repeat (10) cycle();
    chk("idle_ts10", 32'(dut.ts_cnt), 32'd10);

    // Restart and stamp a single spike at ts=5
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    evt.evt_ready = 1'b1;
    run_until_ts(5);
    spike_in = 3'b010;
    cycle();
    chk("single_e0_valid", 32'(evt.evt_valid), 32'd0);
    spike_in = '0;
    cycle();
    chk("single_valid", 32'(evt.evt_valid), 32'd1);
    chk("single_id", 32'(evt.evt_id), 32'd1);
    chk("single_ts", 32'(evt.evt_ts), 32'd5);
    cycle();
    chk("single_gone", 32'(evt.evt_valid), 32'd0);

    // Multi-bit ordering with the consumer stalled
    evt.evt_ready = 1'b0;
    run_until_ts(7);
    spike_in = 3'b111;
    cycle();
    spike_in = '0;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("multi_level", 32'(fifo_level), 32'(i));
    end
    evt.evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("multi_id", 32'(evt.evt_id), 32'(i));
      chk("multi_ts", 32'(evt.evt_ts), 32'd7);
      cycle();
    end
    chk("multi_drained", 32'(evt.evt_valid), 32'd0);

    // Drop while pending is busy; also walks the timestamp through its wrap
    run_until_ts(0);
    spike_in = 3'b111; cycle();
    spike_in = 3'b011; cycle();
    spike_in = 3'b000; cycle();
    chk("drop_count2", 32'(drop_count), 32'd2);
    chk("drop_ovf", 32'(overflow), 32'd1);
    spike_in = 3'b111; cycle();
    chk("third_accept_cnt", 32'(drop_count), 32'd2);
    spike_in = '0;
    repeat (5) cycle();

    // Fill the FIFO, hold one pending bit, drop more, then clear and pop+push
    evt.evt_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      spike_in = ((i % 3 == 0 && i < 9) || i == 10) ? 3'b111 : 3'b000;
      cycle();
    end
    spike_in = '0;
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_pending_held", 32'(dut.mask), 32'b100);
    clear_stats = 1'b1;
    spike_in    = 3'b111;
    cycle();
    clear_stats = 1'b0;
    spike_in    = '0;
    chk("clear_drop", 32'(drop_count), 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);
    evt.evt_ready = 1'b1;
    cycle();
    evt.evt_ready = 1'b0;
    chk("popush_level", 32'(fifo_level), 32'd8);
    chk("popush_tail_id", 32'(m_fifo[7].id), 32'd2);
    evt.evt_ready = 1'b1;
    repeat (10) cycle();

    // Timestamp wrap: event stamped 255, next sample stamped 0
    run_until_ts(255);
    spike_in = 3'b001; cycle();
    spike_in = 3'b100; cycle();
    spike_in = '0;
    chk("wrap_id", 32'(evt.evt_id), 32'd0);
    chk("wrap_ts255", 32'(evt.evt_ts), 32'd255);
    cycle();
    chk("wrap_id2", 32'(evt.evt_id), 32'd2);
    chk("wrap_ts0", 32'(evt.evt_ts), 32'd0);
    repeat (3) cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      enable        = ($urandom % 4) != 0;
      spike_in      = ($urandom % 3 == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      evt.evt_ready = ($urandom % 3) != 0;
      clear_stats   = ($urandom % 40) == 0;
      cycle();
    end
    clear_stats = 1'b0;

    // Reset mid-stream with the FIFO half full
    enable = 1'b1;
    evt.evt_ready = 1'b0;
    spike_in = 3'b111;
    for (int k = 0; k < 30 && fifo_level < 4; k++) cycle();
    chk("half_full", 32'(fifo_level >= 4), 32'd1);
    spike_in = '0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_async_valid", 32'(evt.evt_valid), 32'd0);
    chk("rst_async_level", 32'(fifo_level), 32'd0);
    check_all();
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    evt.evt_ready = 1'b0;
  end
endmodule
